// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage: payload layouts, opcode bit
// positions and the store lane helpers.
package ex_stage_pkg;

    localparam int          XLEN_DEFAULT       = 32;
    localparam logic [31:0] DIV_ZERO_Q_DEFAULT = 32'hFFFF_FFFF;

    localparam int TO_EX_DATA_W  = 156;
    localparam int TO_MEM_DATA_W = 75;
    localparam int EX_FORWARD_W  = 38;

    // div_op is one-hot {div_w, mod_w, div_wu, mod_wu}
    localparam int DIV_OP_DIV_W  = 3;
    localparam int DIV_OP_MOD_W  = 2;
    localparam int DIV_OP_DIV_WU = 1;
    localparam int DIV_OP_MOD_WU = 0;

    // alu_op is one-hot
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // mem_size is one-hot {word, half, byte}
    localparam int MEM_SIZE_B = 0;
    localparam int MEM_SIZE_H = 1;
    localparam int MEM_SIZE_W = 2;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  div_op;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        mem_signed;
        logic [31:0] rkd;
        logic [4:0]  dest;
        logic        gr_we;
        logic        ex_sys;
    } ex_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic        rd_1b;
        logic        rd_2b;
        logic        rd_4b;
        logic        rd_signed;
        logic [4:0]  dest;
        logic        gr_we;
        logic        ex_sys;
    } mem_payload_t;

    function automatic logic [3:0] store_strobe(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] s;
        s = 4'b0000;
        if (size[MEM_SIZE_B])      s = 4'b0001 << addr;
        else if (size[MEM_SIZE_H]) s = 4'b0011 << addr;
        else if (size[MEM_SIZE_W]) s = 4'b1111;
        return s;
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU driven by a one-hot operation select.
module alu
    import ex_stage_pkg::*;
(
    input  logic [11:0] i_alu_op,
    input  logic [31:0] i_src1,
    input  logic [31:0] i_src2,
    output logic [31:0] o_result
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_slt;
    logic        w_sltu;

    assign w_sum  = i_src1 + i_src2;
    assign w_diff = i_src1 - i_src2;
    assign w_slt  = $signed(i_src1) < $signed(i_src2);
    assign w_sltu = i_src1 < i_src2;

    always_comb begin
        o_result = 32'h0;
        if (i_alu_op[ALU_ADD])  o_result = o_result | w_sum;
        if (i_alu_op[ALU_SUB])  o_result = o_result | w_diff;
        if (i_alu_op[ALU_SLT])  o_result = o_result | {31'h0, w_slt};
        if (i_alu_op[ALU_SLTU]) o_result = o_result | {31'h0, w_sltu};
        if (i_alu_op[ALU_AND])  o_result = o_result | (i_src1 & i_src2);
        if (i_alu_op[ALU_NOR])  o_result = o_result | ~(i_src1 | i_src2);
        if (i_alu_op[ALU_OR])   o_result = o_result | (i_src1 | i_src2);
        if (i_alu_op[ALU_XOR])  o_result = o_result | (i_src1 ^ i_src2);
        if (i_alu_op[ALU_SLL])  o_result = o_result | (i_src1 << i_src2[4:0]);
        if (i_alu_op[ALU_SRL])  o_result = o_result | (i_src1 >> i_src2[4:0]);
        if (i_alu_op[ALU_SRA])  o_result = o_result | 32'($signed(i_src1) >>> i_src2[4:0]);
        if (i_alu_op[ALU_LUI])  o_result = o_result | i_src2;
    end

endmodule

// File: rtl/ex_stage_div_iter.sv
// Iterative 32-bit restoring divider: magnitudes are divided over 32 BUSY cycles,
// signs are reapplied combinationally on the way out.
module div_iter
    import ex_stage_pkg::*;
#(
    parameter logic [31:0] DIV_ZERO_Q = DIV_ZERO_Q_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        ack,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r,
    output div_state_t  dbg_state
);

    div_state_t  r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [63:0] r_acc, w_acc_nxt;
    logic [31:0] r_y, w_y_nxt;
    logic        r_q_neg, w_q_neg_nxt;
    logic        r_r_neg, w_r_neg_nxt;
    logic        r_div_zero, w_div_zero_nxt;

    logic [31:0] w_x_abs;
    logic [31:0] w_y_abs;
    logic [32:0] w_diff;

    assign w_x_abs = (signed_op & x[31]) ? -x : x;
    assign w_y_abs = (signed_op & y[31]) ? -y : y;
    // Partial remainder after the shift is 33 bits wide; a set MSB means it stayed below the divisor.
    assign w_diff  = r_acc[63:31] - {1'b0, r_y};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_acc_nxt      = r_acc;
        w_y_nxt        = r_y;
        w_q_neg_nxt    = r_q_neg;
        w_r_neg_nxt    = r_r_neg;
        w_div_zero_nxt = r_div_zero;
        case (r_state)
            DIV_IDLE: begin
                if (start) begin
                    w_state_nxt    = DIV_BUSY;
                    w_cnt_nxt      = 5'd0;
                    w_acc_nxt      = {32'h0, w_x_abs};
                    w_y_nxt        = w_y_abs;
                    w_q_neg_nxt    = signed_op & (x[31] ^ y[31]);
                    w_r_neg_nxt    = signed_op & x[31];
                    w_div_zero_nxt = (y == 32'h0);
                end
            end
            DIV_BUSY: begin
                w_acc_nxt = w_diff[32] ? {r_acc[62:0], 1'b0} : {w_diff[31:0], r_acc[30:0], 1'b1};
                w_cnt_nxt = r_cnt + 5'd1;
                if (r_cnt == 5'd31) w_state_nxt = DIV_DONE;
            end
            DIV_DONE: begin
                if (ack) w_state_nxt = DIV_IDLE;
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = DIV_IDLE;
            w_cnt_nxt   = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DIV_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
        r_acc      <= w_acc_nxt;
        r_y        <= w_y_nxt;
        r_q_neg    <= w_q_neg_nxt;
        r_r_neg    <= w_r_neg_nxt;
        r_div_zero <= w_div_zero_nxt;
    end

    assign done      = (r_state == DIV_DONE);
    assign q         = r_div_zero ? DIV_ZERO_Q : (r_q_neg ? -r_acc[31:0] : r_acc[31:0]);
    assign r         = r_r_neg ? -r_acc[63:32] : r_acc[63:32];
    assign dbg_state = r_state;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: holds the ID payload, computes ALU or div/mod results, issues
// data SRAM requests and publishes the forwarding bundle back to ID.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int          XLEN       = XLEN_DEFAULT,
    parameter logic [31:0] DIV_ZERO_Q = DIV_ZERO_Q_DEFAULT
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_ex,
    input  logic                     ID_to_EX_valid,
    output logic                     EX_allow_in,
    input  logic [TO_EX_DATA_W-1:0]  to_EX_data,
    input  logic                     MEM_allow_in,
    output logic                     EX_to_MEM_valid,
    output logic [TO_MEM_DATA_W-1:0] to_MEM_data,
    output logic                     data_sram_en,
    output logic [3:0]               data_sram_we,
    output logic [XLEN-1:0]          data_sram_addr,
    output logic [XLEN-1:0]          data_sram_wdata,
    output logic [EX_FORWARD_W-1:0]  EX_forward
);

    logic         r_ex_valid;
    ex_payload_t  r_payload;

    logic         w_ready_go;
    logic         w_is_div;
    logic         w_div_signed;
    logic         w_div_done;
    logic [31:0]  w_div_q;
    logic [31:0]  w_div_r;
    div_state_t   w_div_state;
    logic [31:0]  w_alu_result;
    logic [31:0]  w_result;
    logic         w_mem_op;
    logic         w_load;
    logic         w_pending;
    logic [4:0]   w_ex_dest;
    logic [31:0]  w_wdata;
    mem_payload_t w_to_mem;

    assign w_is_div     = |r_payload.div_op;
    assign w_div_signed = r_payload.div_op[DIV_OP_DIV_W] | r_payload.div_op[DIV_OP_MOD_W];
    assign w_ready_go   = ~w_is_div | w_div_done;

    assign EX_allow_in     = ~r_ex_valid | (w_ready_go & MEM_allow_in);
    assign EX_to_MEM_valid = r_ex_valid & w_ready_go;

    always_ff @(posedge clk) begin
        if (reset | wb_ex) begin
            r_ex_valid <= 1'b0;
        end else if (EX_allow_in) begin
            r_ex_valid <= ID_to_EX_valid;
        end
        if (ID_to_EX_valid & EX_allow_in) begin
            r_payload <= ex_payload_t'(to_EX_data);
        end
    end

    alu u_alu (
        .i_alu_op (r_payload.alu_op),
        .i_src1   (r_payload.src1),
        .i_src2   (r_payload.src2),
        .o_result (w_alu_result)
    );

    div_iter #(.DIV_ZERO_Q(DIV_ZERO_Q)) u_div (
        .clk       (clk),
        .reset     (reset),
        .flush     (wb_ex),
        .start     (r_ex_valid & w_is_div),
        .signed_op (w_div_signed),
        .x         (r_payload.src1),
        .y         (r_payload.src2),
        .ack       (MEM_allow_in),
        .done      (w_div_done),
        .q         (w_div_q),
        .r         (w_div_r),
        .dbg_state (w_div_state)
    );

    always_comb begin
        w_result = w_alu_result;
        if (r_payload.div_op[DIV_OP_DIV_W] | r_payload.div_op[DIV_OP_DIV_WU]) w_result = w_div_q;
        if (r_payload.div_op[DIV_OP_MOD_W] | r_payload.div_op[DIV_OP_MOD_WU]) w_result = w_div_r;
    end

    assign w_mem_op = r_payload.mem_we | (|r_payload.mem_size);
    assign w_load   = ~r_payload.mem_we & (|r_payload.mem_size);

    // A squashed or syscall-marked access never reaches the SRAM, including its byte strobes.
    assign data_sram_en   = r_ex_valid & w_mem_op & w_ready_go & MEM_allow_in & ~wb_ex & ~r_payload.ex_sys;
    assign data_sram_we   = (r_payload.mem_we ? store_strobe(r_payload.mem_size, w_result[1:0]) : 4'b0000)
                            & {4{data_sram_en}};
    assign data_sram_addr = w_result;

    always_comb begin
        w_wdata = r_payload.rkd;
        if (r_payload.mem_size[MEM_SIZE_B])      w_wdata = {4{r_payload.rkd[7:0]}};
        else if (r_payload.mem_size[MEM_SIZE_H]) w_wdata = {2{r_payload.rkd[15:0]}};
    end
    assign data_sram_wdata = w_wdata;

    assign w_ex_dest  = r_payload.dest & {5{r_ex_valid & r_payload.gr_we}};
    assign w_pending  = r_ex_valid & (w_load | (w_is_div & (w_div_state != DIV_DONE)));
    assign EX_forward = {w_ex_dest, w_pending, w_result};

    always_comb begin
        w_to_mem.pc         = r_payload.pc;
        w_to_mem.alu_result = w_result;
        w_to_mem.rd_1b      = w_load & r_payload.mem_size[MEM_SIZE_B];
        w_to_mem.rd_2b      = w_load & r_payload.mem_size[MEM_SIZE_H];
        w_to_mem.rd_4b      = w_load & r_payload.mem_size[MEM_SIZE_W];
        w_to_mem.rd_signed  = r_payload.mem_signed;
        w_to_mem.dest       = r_payload.dest;
        w_to_mem.gr_we      = r_payload.gr_we;
        w_to_mem.ex_sys     = r_payload.ex_sys;
    end
    assign to_MEM_data = w_to_mem;

endmodule
